lif_stdp_neuron: RTL and testbench

- Parametrised leaky integrate-and-fire neuron with N_IN synapses.
- Each synapse has its own weight register with on-chip STDP learning.
- Adds what the previous single-neuron block lacks: a real leaky membrane accumulator, a programmable threshold, a refractory period, saturating arithmetic and a weight readback port.
- Sits between the input spike fabric and downstream neurons; spike_out feeds the next layer.

---
 rtl/lif_stdp_neuron.sv | 96 +++++++++
 tb/tb_lif_stdp_neuron.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/lif_stdp_neuron.sv
// lif_stdp_neuron: leaky integrate-and-fire neuron with per-synapse STDP weights
module lif_stdp_neuron #(
    parameter int N_IN       = 8,
    parameter int W_BITS     = 8,
    parameter int V_BITS     = 10,
    parameter int LEAK_SHIFT = 2,
    parameter int REFRAC     = 3,
    parameter int STDP_WIN   = 4,
    parameter int W_INIT     = 16,
    localparam int SEL_W     = N_IN > 1 ? $clog2(N_IN) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_IN-1:0]   inputs,
    input  logic              learn,
    input  logic [V_BITS-1:0] threshold,
    output logic              spike_out,
    output logic [V_BITS-1:0] membrane,
    input  logic [SEL_W-1:0]  w_sel,
    output logic [W_BITS-1:0] w_rd
);
    localparam int SUM_W = W_BITS + $clog2(N_IN);
    localparam int VX    = V_BITS + 1;
    localparam int TR_W  = $clog2(STDP_WIN + 1);
    localparam int RC_W  = REFRAC > 0 ? $clog2(REFRAC + 1) : 1;

    typedef enum logic {INTEGRATE, REFRACTORY} state_t;

    state_t            state, state_nx;
    logic [V_BITS-1:0] v, v_sat;
    logic [VX-1:0]     v_ext;
    logic [SUM_W-1:0]  sum;
    logic [RC_W-1:0]   rc;
    logic [TR_W-1:0]   post_tr;
    logic [TR_W-1:0]   pre_tr [N_IN];
    logic [W_BITS-1:0] w [N_IN];
    logic              fire;

    assign membrane = v;

    // synaptic sum, leaky saturating membrane update and fire decision
    always_comb begin
        sum = '0;
        for (int i = 0; i < N_IN; i++)
            sum = sum + (inputs[i] ? SUM_W'(w[i]) : SUM_W'(0));
        v_ext = {1'b0, v} - VX'(v >> LEAK_SHIFT) + VX'(sum);
        v_sat = v_ext[V_BITS] ? '1 : v_ext[V_BITS-1:0];
        fire  = state == INTEGRATE && v_sat >= threshold;
        state_nx = (fire && REFRAC > 0) ? REFRACTORY :
                   (state == REFRACTORY && rc == RC_W'(1)) ? INTEGRATE : state;
    end

    // weight readback, zero for selects beyond the synapse count
    always_comb begin
        w_rd = '0;
        for (int i = 0; i < N_IN; i++)
            if (w_sel == SEL_W'(i)) w_rd = w[i];
    end

    // state register, membrane, spike and refractory counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= INTEGRATE;
            v         <= '0;
            spike_out <= 1'b0;
            rc        <= '0;
        end else begin
            state     <= state_nx;
            spike_out <= fire;
            v         <= (state == INTEGRATE && !fire) ? v_sat : '0;
            rc        <= fire ? RC_W'(REFRAC) : (rc != '0 ? rc - 1'b1 : rc);
        end
    end

    // pre/post traces run continuously; weights step by at most one when learning
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            post_tr <= '0;
            for (int i = 0; i < N_IN; i++) begin
                pre_tr[i] <= '0;
                w[i]      <= W_BITS'(W_INIT);
            end
        end else begin
            post_tr <= fire ? TR_W'(STDP_WIN) : (post_tr != '0 ? post_tr - 1'b1 : post_tr);
            for (int i = 0; i < N_IN; i++) begin
                pre_tr[i] <= inputs[i] ? TR_W'(STDP_WIN) : (pre_tr[i] != '0 ? pre_tr[i] - 1'b1 : pre_tr[i]);
                if (learn) begin
                    if (fire && (pre_tr[i] != '0 || inputs[i]) && w[i] != '1)
                        w[i] <= w[i] + 1'b1;
                    else if (!fire && inputs[i] && post_tr != '0 && w[i] != '0)
                        w[i] <= w[i] - 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_lif_stdp_neuron.sv
// tb_lif_stdp_neuron: directed checks of integration, refractory, STDP and reset
`timescale 1ns/1ps
module tb_lif_stdp_neuron;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] in0 = '0;
    logic       learn0 = 1'b0;
    logic [9:0] thr0 = 10'd40;
    logic       spk0;
    logic [9:0] mem0;
    logic [2:0] sel0 = '0;
    logic [7:0] wrd0;
    logic [5:0] in1 = '0;
    logic [9:0] thr1 = '0;
    logic       spk1;
    logic [9:0] mem1;
    logic [2:0] sel1 = '0;
    logic [7:0] wrd1;
    int passed = 0;
    int total = 0;

    always #10 clk = ~clk;

    lif_stdp_neuron u0 (
        .clk(clk), .reset(reset), .inputs(in0), .learn(learn0), .threshold(thr0),
        .spike_out(spk0), .membrane(mem0), .w_sel(sel0), .w_rd(wrd0)
    );

    lif_stdp_neuron #(.N_IN(6), .REFRAC(0)) u1 (
        .clk(clk), .reset(reset), .inputs(in1), .learn(1'b0), .threshold(thr1),
        .spike_out(spk1), .membrane(mem1), .w_sel(sel1), .w_rd(wrd1)
    );

    task automatic step(input logic [7:0] a);
        in0 = a;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        in0 = '0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        total++; if (spk0 !== 1'b0) $display("FAIL reset_spike: got %0d expected 0", spk0); else passed++;
        total++; if (mem0 !== 10'd0) $display("FAIL reset_membrane: got %0d expected 0", mem0); else passed++;
        for (int i = 0; i < 8; i++) begin
            sel0 = 3'(i);
            #1;
            total++; if (wrd0 !== 8'd16) $display("FAIL reset_weight%0d: got %0d expected 16", i, wrd0); else passed++;
        end
        reset = 1'b1;
    endtask

    task automatic test_integrate();
        int exp_v [8] = '{16, 28, 37, 0, 0, 0, 0, 16};
        logic [7:0] exp_s = 8'b0000_1000;
        learn0 = 1'b0;
        thr0 = 10'd40;
        for (int k = 0; k < 8; k++) begin
            step(8'h01);
            total++; if (mem0 !== 10'(exp_v[k])) $display("FAIL integ_v_edge%0d: got %0d expected %0d", k + 1, mem0, exp_v[k]); else passed++;
            total++; if (spk0 !== exp_s[k]) $display("FAIL integ_spike_edge%0d: got %0d expected %0d", k + 1, spk0, exp_s[k]); else passed++;
        end
        sel0 = 3'd0;
        #1;
        total++; if (wrd0 !== 8'd16) $display("FAIL frozen_weight0: got %0d expected 16", wrd0); else passed++;
        do_reset();
    endtask

    task automatic test_threshold_zero();
        logic [5:0] pats [5] = '{6'h3f, 6'h00, 6'h15, 6'h2a, 6'h01};
        thr1 = '0;
        for (int k = 0; k < 5; k++) begin
            in1 = pats[k];
            step(8'h00);
            total++; if (spk1 !== 1'b1) $display("FAIL thr0_spike%0d: got %0d expected 1", k, spk1); else passed++;
            total++; if (mem1 !== 10'd0) $display("FAIL thr0_v%0d: got %0d expected 0", k, mem1); else passed++;
        end
    endtask

    task automatic test_readback();
        sel1 = 3'd5;
        #1;
        total++; if (wrd1 !== 8'd16) $display("FAIL rd_sel5: got %0d expected 16", wrd1); else passed++;
        sel1 = 3'd6;
        #1;
        total++; if (wrd1 !== 8'd0) $display("FAIL rd_sel6: got %0d expected 0", wrd1); else passed++;
        sel1 = 3'd7;
        #1;
        total++; if (wrd1 !== 8'd0) $display("FAIL rd_sel7: got %0d expected 0", wrd1); else passed++;
    endtask

    task automatic test_potentiation();
        do_reset();
        learn0 = 1'b1;
        thr0 = 10'd40;
        step(8'h02);
        step(8'h01);
        step(8'h01);
        step(8'h01);
        total++; if (spk0 !== 1'b1) $display("FAIL pot_fire: got %0d expected 1", spk0); else passed++;
        for (int i = 0; i < 8; i++) begin
            sel0 = 3'(i);
            #1;
            total++; if (wrd0 !== (i < 2 ? 8'd17 : 8'd16)) $display("FAIL pot_weight%0d: got %0d expected %0d", i, wrd0, (i < 2 ? 17 : 16)); else passed++;
        end
    endtask

    task automatic test_depression();
        step(8'h00);
        step(8'h04);
        sel0 = 3'd2;
        #1;
        total++; if (wrd0 !== 8'd15) $display("FAIL dep_weight2: got %0d expected 15", wrd0); else passed++;
        step(8'h00);
        step(8'h00);
        step(8'h00);
        step(8'h04);
        sel0 = 3'd2;
        #1;
        total++; if (wrd0 !== 8'd15) $display("FAIL dep_expired_weight2: got %0d expected 15", wrd0); else passed++;
        total++; if (mem0 !== 10'd15) $display("FAIL dep_membrane: got %0d expected 15", mem0); else passed++;
        sel0 = 3'd0;
        #1;
        total++; if (wrd0 !== 8'd17) $display("FAIL dep_weight0: got %0d expected 17", wrd0); else passed++;
    endtask

    task automatic test_saturation();
        do_reset();
        learn0 = 1'b1;
        thr0 = '0;
        for (int k = 0; k < 300; k++) begin
            step(8'h01);
            step(8'h00);
            step(8'h00);
            step(8'h00);
        end
        sel0 = 3'd0;
        #1;
        total++; if (wrd0 !== 8'd255) $display("FAIL sat_weight0: got %0d expected 255", wrd0); else passed++;
        sel0 = 3'd1;
        #1;
        total++; if (wrd0 !== 8'd16) $display("FAIL sat_weight1: got %0d expected 16", wrd0); else passed++;
    endtask

    task automatic test_floor();
        do_reset();
        learn0 = 1'b1;
        sel0 = 3'd3;
        for (int k = 0; k < 40; k++) begin
            thr0 = '0;
            step(8'h00);
            thr0 = 10'h3ff;
            step(8'h08);
            for (int j = 0; j < 4; j++) step(8'h00);
            if (k == 9) begin
                total++; if (wrd0 !== 8'd6) $display("FAIL floor_weight3_mid: got %0d expected 6", wrd0); else passed++;
            end
        end
        total++; if (wrd0 !== 8'd0) $display("FAIL floor_weight3: got %0d expected 0", wrd0); else passed++;
        sel0 = 3'd0;
        #1;
        total++; if (wrd0 !== 8'd16) $display("FAIL floor_weight0: got %0d expected 16", wrd0); else passed++;
    endtask

    task automatic test_reset_refrac();
        do_reset();
        learn0 = 1'b1;
        thr0 = 10'd40;
        sel0 = 3'd0;
        for (int k = 0; k < 4; k++) step(8'h01);
        total++; if (spk0 !== 1'b1) $display("FAIL rr_fire: got %0d expected 1", spk0); else passed++;
        total++; if (wrd0 !== 8'd17) $display("FAIL rr_weight_pre: got %0d expected 17", wrd0); else passed++;
        reset = 1'b0;
        #1;
        total++; if (spk0 !== 1'b0) $display("FAIL rr_spike: got %0d expected 0", spk0); else passed++;
        total++; if (mem0 !== 10'd0) $display("FAIL rr_membrane: got %0d expected 0", mem0); else passed++;
        total++; if (wrd0 !== 8'd16) $display("FAIL rr_weight0: got %0d expected 16", wrd0); else passed++;
        @(posedge clk);
        #1;
        reset = 1'b1;
        step(8'h01);
        total++; if (mem0 !== 10'd16) $display("FAIL rr_resume_v: got %0d expected 16", mem0); else passed++;
        total++; if (spk0 !== 1'b0) $display("FAIL rr_resume_spike: got %0d expected 0", spk0); else passed++;
    endtask

    initial begin
        test_reset();
        test_integrate();
        test_threshold_zero();
        test_readback();
        test_potentiation();
        test_depression();
        test_saturation();
        test_floor();
        test_reset_refrac();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
